// File: rtl/aes_decryption_iter.sv
// Iterative AES-128/192/256 inverse cipher: key expansion then one round per clock.
// Define AES_KEY_REUSE_EN to keep the last expanded key and skip EXPAND on a repeat key.

package aes_gf_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the field inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] x);
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] y;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = x[127-8*(4*c+k) -: 8];
            for (int r = 0; r < 4; r++) begin
                b = '0;
                for (int k = 0; k < 4; k++) b = b ^ gmul(m[(k-r+4)%4], a[k]);
                y[127-8*(4*c+r) -: 8] = b;
            end
        end
        return y;
    endfunction
endpackage

module aes_sbox
    import aes_gf_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] v;
    assign v = ginv(a);
    assign s = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
endmodule

module aes_inv_sbox
    import aes_gf_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] v;
    assign v = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    assign s = ginv(v);
endmodule

module aes_decryption_iter
    import aes_gf_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [KEY_BITS-1:0] key_i,
    input  logic [127:0]        ciphertext_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [127:0]        plaintext_o,
    output logic                valid_o,
    input  logic                yumi_i
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_decryption_iter: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;
    state_t state, state_nx;

    logic [31:0]  w [NW];
    logic [5:0]   cnt;
    logic [2:0]   kpos;
    logic [7:0]   rcon;
    logic [3:0]   rnd;
    logic [127:0] blk, ct, pt;
    logic         accept, hit, last_word;

    assign ready_o     = (state == IDLE) && !reset_i;
    assign valid_o     = (state == DONE);
    assign plaintext_o = pt;
    assign accept      = valid_i && ready_o;
    assign last_word   = (cnt == 6'(NW - 1));

    // key schedule: cnt is the word being produced, kpos tracks cnt mod NK
    logic [31:0] prev, back, sub_in, sub_out, nw;
    assign prev   = w[cnt - 6'd1];
    assign back   = w[cnt - 6'(NK)];
    assign sub_in = (kpos == '0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar i = 0; i < 4; i++) begin : g_ks
        aes_sbox u_sbox (
            .a(sub_in[8*i +: 8]),
            .s(sub_out[8*i +: 8])
        );
    end

    always_comb begin
        nw = back ^ prev;
        if (kpos == '0) nw = back ^ sub_out ^ {rcon, 24'h0};
        else if (NK == 8 && kpos == 3'd4) nw = back ^ sub_out;
    end

    // the final word is still in flight on the last EXPAND edge
    logic [127:0] rk_last, rk, sb, ark, round;
    logic [5:0]   base;
    assign rk_last = {w[NW-4], w[NW-3], w[NW-2], (state == EXPAND) ? nw : w[NW-1]};
    assign base    = {rnd, 2'b00};
    assign rk      = {w[base], w[base+6'd1], w[base+6'd2], w[base+6'd3]};

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            aes_inv_sbox u_isbox (
                .a(blk[127-8*(4*((c-r+4)%4)+r) -: 8]),
                .s(sb[127-8*(4*c+r) -: 8])
            );
        end
    end

    assign ark   = sb ^ rk;
    assign round = (rnd == '0) ? ark : inv_mix(ark);

`ifdef AES_KEY_REUSE_EN
    logic [KEY_BITS-1:0] ckey;
    logic                cvalid;
    assign hit = cvalid && (key_i == ckey);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cvalid <= 1'b0;
            ckey   <= '0;
        end else if (accept && !hit) begin
            cvalid <= 1'b0;
            ckey   <= key_i;
        end else if (state == EXPAND && last_word) begin
            cvalid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = hit ? DECRYPT : EXPAND;
            EXPAND:  if (last_word) state_nx = DECRYPT;
            DECRYPT: if (rnd == '0) state_nx = DONE;
            DONE:    if (yumi_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= '0;
            kpos  <= '0;
            rcon  <= 8'h01;
            rnd   <= '0;
            blk   <= '0;
            ct    <= '0;
            pt    <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (accept) begin
                    ct   <= ciphertext_i;
                    cnt  <= 6'(NK);
                    kpos <= '0;
                    rcon <= 8'h01;
                    rnd  <= 4'(NR - 1);
                    if (hit) blk <= ciphertext_i ^ rk_last;
                end
                EXPAND: begin
                    cnt  <= cnt + 6'd1;
                    kpos <= (kpos == 3'(NK - 1)) ? '0 : kpos + 3'd1;
                    if (kpos == '0) rcon <= xtime(rcon);
                    if (last_word) blk <= ct ^ rk_last;
                end
                DECRYPT: begin
                    blk <= round;
                    if (rnd == '0) pt <= round;
                    else rnd <= rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // round-key store has no reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (accept && !hit) begin
                for (int m = 0; m < NK; m++) w[m] <= key_i[KEY_BITS-1-32*m -: 32];
            end else if (state == EXPAND) begin
                w[cnt] <= nw;
            end
        end
    end
endmodule

// File: tb/tb_aes_decryption_iter.sv
// Bench for aes_decryption_iter: all three key sizes side by side,
// checked against a forward-cipher reference model.

module tb_aes_decryption_iter;
`ifdef AES_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [255:0] key  [3];
    logic [127:0] ct   [3];
    logic         vin  [3];
    logic         rdy  [3];
    logic [127:0] pt   [3];
    logic         vout [3];
    logic         yumi [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int KB = 128 + 64 * k;
        aes_decryption_iter #(.KEY_BITS(KB)) u_dut (
            .clk_i(clk),
            .reset_i(rst),
            .key_i(key[k][KB-1:0]),
            .ciphertext_i(ct[k]),
            .valid_i(vin[k]),
            .ready_o(rdy[k]),
            .plaintext_o(pt[k]),
            .valid_o(vout[k]),
            .yumi_i(yumi[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (forward cipher) ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // walk the multiplicative group with generator 3 and its inverse together
    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    function automatic logic [127:0] encrypt(input logic [255:0] kk, input int nk,
                                             input logic [127:0] p);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] r;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = kk[32*(nk-1-i) +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8];
        for (int rd = 0; rd <= nr; rd++) begin
            if (rd > 0) begin
                for (int b = 0; b < 16; b++) t[b] = sbox[s[b]];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
                if (rd != nr) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c+q] = s[4*c+q] ^ w[4*rd+c][31-8*q -: 8];
        end
        r = '0;
        for (int b = 0; b < 16; b++) r[127-8*b -: 8] = s[b];
        return r;
    endfunction

    // expanded-key cache model
    bit           cache_ok  [3];
    logic [255:0] cache_key [3];

    function automatic int exp_lat(input int k, input logic [255:0] kk);
        int nk, nr;
        nk = 4 + 2 * k;
        nr = nk + 6;
        if (REUSE && cache_ok[k] && cache_key[k] == kk) return nr;
        return 4 * (nr + 1) - nk + nr;
    endfunction

    function automatic logic [255:0] rand_key(input int k);
        logic [255:0] kk;
        kk = '0;
        for (int j = 0; j < 8; j++) kk = {kk[223:0], $urandom};
        return kk >> (128 - 64 * k);
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- one request, start to yumi ----------------
    task automatic run_req(input int k, input logic [255:0] kk, input logic [127:0] c,
                           input logic [127:0] exp, input int hold, input bit poke);
        int n, lat;
        bit busy_rdy, stable;
        logic [127:0] held;
        lat = exp_lat(k, kk);
        @(negedge clk);
        check("ready_idle", 256'(rdy[k]), 256'(1));
        key[k] = kk;
        ct[k]  = c;
        vin[k] = 1'b1;
        @(negedge clk);
        vin[k] = 1'b0;
        if (lat != k * 2 + 10) cache_ok[k] = 1'b0;
        n = 0;
        busy_rdy = 1'b0;
        while (!vout[k] && n < 200) begin
            if (rdy[k]) busy_rdy = 1'b1;
            if (poke) begin
                vin[k] = 1'($urandom_range(0, 1));
                key[k] = rand_key(2);
                ct[k]  = rand_blk();
            end
            @(negedge clk);
            n++;
        end
        vin[k] = 1'b0;
        if (vout[k]) begin
            cache_ok[k]  = 1'b1;
            cache_key[k] = kk;
        end
        check("latency", 256'(n), 256'(lat));
        check("busy_ready", 256'(busy_rdy || rdy[k]), 256'(0));
        check("plaintext", 256'(pt[k]), 256'(exp));
        if (hold > 0) begin
            stable = 1'b1;
            held = pt[k];
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!vout[k] || pt[k] !== held || rdy[k]) stable = 1'b0;
            end
            check("backpressure", 256'(stable), 256'(1));
        end
        yumi[k] = 1'b1;
        @(negedge clk);
        yumi[k] = 1'b0;
        check("valid_drop", 256'(vout[k]), 256'(0));
        check("ready_back", 256'(rdy[k]), 256'(1));
    endtask

    typedef struct {
        int           k;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           hold;
        bit           poke;
    } vec_t;

    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KREV =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PTK  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        vec_t         vecs [$];
        logic [255:0] kk;
        logic [127:0] p;
        bit           seen;

        build_sbox();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            key[k] = '0; ct[k] = '0; vin[k] = 1'b0; yumi[k] = 1'b0;
            cache_ok[k] = 1'b0; cache_key[k] = '0;
        end

        vecs.push_back('{0, K128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PTK, 0, 1'b0});
        vecs.push_back('{1, K192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PTK, 0, 1'b0});
        vecs.push_back('{2, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PTK, 0, 1'b1});
        vecs.push_back('{2, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PTK, 20, 1'b0});
        p = rand_blk();
        vecs.push_back('{2, KREV, encrypt(KREV, 8, p), p, 0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            kk = rand_key(i % 3);
            p = rand_blk();
            vecs.push_back('{i % 3, kk, encrypt(kk, 4 + 2 * (i % 3), p), p, 0, 1'b0});
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", 256'(rdy[k]), 256'(0));
            check("reset_valid", 256'(vout[k]), 256'(0));
            check("reset_plaintext", 256'(pt[k]), 256'(0));
        end
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_req(vecs[i].k, vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].hold, vecs[i].poke);

        // reset 30 cycles into an AES-256 request
        @(negedge clk);
        key[2] = K256;
        ct[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        vin[2] = 1'b1;
        @(negedge clk);
        vin[2] = 1'b0;
        cache_ok[2] = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_ready", 256'(rdy[2]), 256'(0));
        check("midreset_valid", 256'(vout[2]), 256'(0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cache_ok[k] = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (vout[2]) seen = 1'b1;
        end
        check("abort_no_valid", 256'(seen), 256'(0));
        run_req(2, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PTK, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_decryption_iter.md
Name: aes_decryption_iter

Overview:
- Parametrised, iterative AES inverse cipher, one round per cycle. Next generation of the fixed AES-256 multicycle decryption block.
- Key size selectable at elaboration: 128, 192 or 256.
- Adds valid/ready input and valid/yumi output handshakes, on-chip key expansion into a round-key store, and an optional expanded-key reuse cache.
- Sits between the ciphertext source and the plaintext consumer in the decryption chip.

Parameters:
- KEY_BITS, 256, AES key length; legal values 128/192/256, anything else is an elaboration error.
- NK (derived), KEY_BITS/32, key words: 4/6/8.
- NR (derived), NK+6, round count: 10/12/14.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- key_i  in  KEY_BITS  cipher key, MSB = first key byte
- ciphertext_i  in  128  ciphertext block, MSB = byte 0
- valid_i  in  1  key_i/ciphertext_i valid
- ready_o  out  1  block can accept a new request
- plaintext_o  out  128  decrypted block, MSB = byte 0
- valid_o  out  1  plaintext_o valid
- yumi_i  in  1  consumer takes plaintext_o; legal only while valid_o=1

Behaviour:
- Reset values:
  - state=IDLE, ready_o=0 during reset, then 1 in IDLE
  - valid_o=0, plaintext_o=0
  - round counters 0, key cache invalid
- Reset mid-operation aborts the current request with no output.
- FSM states: IDLE, EXPAND, DECRYPT, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o, latch ciphertext_i and key_i.
  - Load words w[0..NK-1] from key_i, then go to EXPAND.
- EXPAND:
  - One word per cycle: w[i] = w[i-NK] ^ f(w[i-1]).
  - f = SubWord(RotWord)^Rcon when i%NK==0.
  - f = SubWord only when NK==8 and i%8==4.
  - Otherwise f is identity.
  - Runs 4*(NR+1)-NK cycles (40/46/52).
  - On the last word, the state register becomes ct ^ rk[NR]; go to DECRYPT.
  - rk[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- DECRYPT:
  - Cycles r = NR-1 down to 0, one per cycle.
  - Each cycle: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - InvMixColumns is skipped when r==0.
  - After r==0, plaintext_o = state; go to DONE.
- DONE:
  - valid_o=1; plaintext_o held stable while yumi_i=0 (backpressure is unbounded).
  - On yumi_i, valid_o drops the next cycle and the FSM returns to IDLE.
  - ready_o stays 0 until back in IDLE, so there is no same-cycle yumi/accept.
- Latency from the accept edge to valid_o=1 is (4*(NR+1)-NK) + NR cycles: 50/58/66.
- ready_o=0 in every state except IDLE. valid_i is ignored when ready_o=0.
- Rcon is generated by xtime iteration starting at 0x01; the byte wraps with reduction polynomial 0x11B.
- S-boxes instantiate the codebase's byte primitives: aes_sbox for key expansion, aes_inv_sbox for the data path.
- Round-key store: 4*(NR+1) 32-bit flops, written only in EXPAND, no reset required.
- Byte/column ordering follows FIPS-197: byte 0 is MSB, columns are filled column-major.

Optional Feature:
- Macro: AES_KEY_REUSE_EN
- With it defined:
  - A register holds the last fully expanded key plus a cache-valid bit.
  - On accept, if cache-valid && key_i == cached key, EXPAND is skipped.
  - The state register loads ct ^ rk[NR] on the accept edge and the FSM goes straight to DECRYPT; latency is NR cycles (10/12/14).
  - Cache-valid is set when EXPAND completes; it is cleared by reset and by an EXPAND aborted by reset.
- Without it: every request runs EXPAND; there is no extra storage and latency is always the full figure.

Test Plan:
- KEY_BITS=128: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, valid_o exactly 50 cycles after accept.
- KEY_BITS=192: key 000102..17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> same pt, latency 58.
- KEY_BITS=256: key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> same pt, latency 66; ready_o=0 throughout and valid_i pulses during busy are ignored.
- Backpressure: hold yumi_i=0 for 20 cycles in DONE -> valid_o=1 and plaintext_o constant; after yumi_i, valid_o=0 next cycle and ready_o=1.
- Reset at cycle 30 of an AES-256 request -> valid_o never rises; a fresh request afterwards produces the correct pt with the full 66-cycle latency (cache invalid).
- AES_KEY_REUSE_EN, KEY_BITS=256: two back-to-back requests with the same key -> second completes in 14 cycles with the correct pt; a third request with key 1f1e..00 takes 66 cycles.
